// File: rtl/noc_request_axilite_arb_pkg.sv
// noc_request_axilite_arb_pkg: FSM encoding, Piton request header fields and flit-count math.
// Field macros default to a 64-bit flit layout unless the Piton define set is already loaded.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_TYPE
`define MSG_TYPE 29:22
`endif
`ifndef MSG_LENGTH
`define MSG_LENGTH 37:30
`endif
`ifndef MSG_ADDR
`define MSG_ADDR 63:0
`endif
`ifndef MSG_ADDR_WIDTH
`define MSG_ADDR_WIDTH 64
`endif
`ifndef MSG_TYPE_NC_LOAD_REQ
`define MSG_TYPE_NC_LOAD_REQ 8'd14
`endif
`ifndef MSG_TYPE_NC_STORE_REQ
`define MSG_TYPE_NC_STORE_REQ 8'd15
`endif

package noc_request_axilite_arb_pkg;
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, DATA} req_state_e;

    localparam int NOC_W = `NOC_DATA_WIDTH;
    localparam int DEF_FLITS = 512 / NOC_W;

    function automatic int flit_count(input int data_width);
        return data_width / NOC_W;
    endfunction

    function automatic logic [NOC_W-1:0] hdr0(input logic store, input int flits);
        logic [NOC_W-1:0] h;
        h = '0;
        h[`MSG_TYPE] = store ? `MSG_TYPE_NC_STORE_REQ : `MSG_TYPE_NC_LOAD_REQ;
        h[`MSG_LENGTH] = store ? 8'(2 + flits) : 8'd2;
        return h;
    endfunction
endpackage

// File: rtl/noc_request_axilite_arb_credit_ctr.sv
// noc_req_credit_ctr: outstanding-request counter that never underflows, with a full flag at MAX.
module noc_req_credit_ctr #(
    parameter int MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [3:0] cnt_o,
    output logic       full_o
);
    logic [3:0] cnt_q, cnt_d;
    logic dec_ok;

    assign dec_ok = dec_i && cnt_q != 4'd0;
    assign cnt_d = (inc_i && !dec_ok && cnt_q != 4'hf) ? cnt_q + 4'd1 :
                   (dec_ok && !inc_i) ? cnt_q - 4'd1 : cnt_q;
    assign cnt_o = cnt_q;
    assign full_o = cnt_q >= 4'(MAX);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/noc_request_axilite_arb.sv
// noc_request_axilite_arb: AXI-lite AR/AW+W round-robin onto one Piton NoC request channel.
// Build option AXILITE_REQ_RD_PRIORITY_EN: eligible reads always beat writes.
module noc_request_axilite_arb
    import noc_request_axilite_arb_pkg::*;
#(
    parameter int AXI_LITE_DATA_WIDTH = 512,
    parameter int AXI_LITE_ADDR_WIDTH = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                             s_axi_arvalid,
    output logic                             s_axi_arready,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                             s_axi_awvalid,
    output logic                             s_axi_awready,
    input  logic [AXI_LITE_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_LITE_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                             s_axi_wvalid,
    output logic                             s_axi_wready,
    output logic [`NOC_DATA_WIDTH-1:0]       noc_data_out,
    output logic                             noc_valid_out,
    input  logic                             noc_ready_in,
    input  logic                             load_ack_done,
    input  logic                             store_ack_done,
    output logic [3:0]                       rd_outstanding,
    output logic [3:0]                       wr_outstanding
);
    localparam int N = flit_count(AXI_LITE_DATA_WIDTH);
    localparam int SB = AXI_LITE_DATA_WIDTH / 8;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    req_state_e state_q, state_d;
    logic [AXI_LITE_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_LITE_DATA_WIDTH-1:0] data_q, data_d, wdata_m;
    logic [CW-1:0] flit_q, flit_d;
    logic store_q, store_d, last_wr_q, last_wr_d;
    logic rd_full, wr_full, rd_el, wr_el, grant_rd, grant_wr, can_grant;
    logic [`NOC_DATA_WIDTH-1:0] hdr1;

    assign can_grant = state_q == IDLE && !rst;
    assign rd_el = s_axi_arvalid && !rd_full;
    assign wr_el = s_axi_awvalid && s_axi_wvalid && !wr_full;
`ifdef AXILITE_REQ_RD_PRIORITY_EN
    assign grant_wr = can_grant && wr_el && !rd_el;
`else
    assign grant_wr = can_grant && wr_el && (!rd_el || !last_wr_q);
`endif
    assign grant_rd = can_grant && rd_el && !grant_wr;
    assign s_axi_arready = grant_rd;
    assign s_axi_awready = grant_wr;
    assign s_axi_wready = grant_wr;

    // Strobes are applied at capture so the DATA state just slices the register.
    always_comb begin
        wdata_m = '0;
        for (int i = 0; i < SB; i++)
            wdata_m[i*8 +: 8] = s_axi_wstrb[i] ? s_axi_wdata[i*8 +: 8] : 8'h00;
    end

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        data_d = data_q;
        store_d = store_q;
        flit_d = flit_q;
        last_wr_d = last_wr_q;
        if (grant_rd || grant_wr) begin
            state_d = HDR0;
            addr_d = grant_wr ? s_axi_awaddr : s_axi_araddr;
            data_d = wdata_m;
            store_d = grant_wr;
            flit_d = '0;
`ifndef AXILITE_REQ_RD_PRIORITY_EN
            last_wr_d = grant_wr;
`endif
        end else if (noc_ready_in && state_q != IDLE) begin
            state_d = state_q == HDR0 ? HDR1 :
                      state_q == HDR1 ? HDR2 :
                      state_q == HDR2 ? (store_q ? DATA : IDLE) :
                      flit_q == LAST ? IDLE : DATA;
            flit_d = state_q == DATA ? flit_q + 1'b1 : flit_q;
        end
    end

    always_comb begin
        hdr1 = '0;
        hdr1[`MSG_ADDR] = `MSG_ADDR_WIDTH'(addr_q);
    end

    assign noc_valid_out = state_q != IDLE;
    assign noc_data_out = state_q == HDR0 ? hdr0(store_q, N) :
                          state_q == HDR1 ? hdr1 :
                          state_q == DATA ? data_q[flit_q*NOC_W +: NOC_W] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            store_q <= 1'b0;
            flit_q <= '0;
            last_wr_q <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            data_q <= data_d;
            store_q <= store_d;
            flit_q <= flit_d;
            last_wr_q <= last_wr_d;
        end
    end

    noc_req_credit_ctr #(.MAX(MAX_OUTSTANDING)) u_rd_ctr (
        .clk(clk), .rst(rst), .inc_i(grant_rd), .dec_i(load_ack_done),
        .cnt_o(rd_outstanding), .full_o(rd_full)
    );

    noc_req_credit_ctr #(.MAX(MAX_OUTSTANDING)) u_wr_ctr (
        .clk(clk), .rst(rst), .inc_i(grant_wr), .dec_i(store_ack_done),
        .cnt_o(wr_outstanding), .full_o(wr_full)
    );
endmodule

// File: tb/tb_noc_request_axilite_arb.sv
// tb_noc_request_axilite_arb: random AXI-lite traffic against a packet-level reference model;
// expected flits are queued at grant time and a separate monitor checks every presented flit.
module tb_noc_request_axilite_arb;
    localparam int DW = 512, AW = 64, NW = 64, N = DW / NW, MAXO = 2;
    localparam logic [7:0] T_LD = 8'd14, T_ST = 8'd15;

    logic clk = 0, rst = 1;
    logic [AW-1:0] araddr = '0, awaddr = '0;
    logic arvalid = 0, awvalid = 0, wvalid = 0;
    logic arready, awready, wready;
    logic [DW-1:0] wdata = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic [NW-1:0] noc_data;
    logic noc_valid, noc_ready = 0, ld_ack = 0, st_ack = 0;
    logic [3:0] rd_out, wr_out;

    int checks = 0, errors = 0;
    logic [NW-1:0] exp_q[$];
    int m_left = 0, m_rd = 0, m_wr = 0, rd_grants = 0, wr_grants = 0, rd_seen = 0, wr_seen = 0;
    bit m_last_wr = 1, idle_m, rel, wel, gr, gw, done;

    always #5 clk = ~clk;

    noc_request_axilite_arb #(
        .AXI_LITE_DATA_WIDTH(DW), .AXI_LITE_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .noc_data_out(noc_data), .noc_valid_out(noc_valid), .noc_ready_in(noc_ready),
        .load_ack_done(ld_ack), .store_ack_done(st_ack),
        .rd_outstanding(rd_out), .wr_outstanding(wr_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input bit store, input logic [AW-1:0] addr,
                            input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        logic [NW-1:0] f;
        exp_q.push_back((NW'(store ? T_ST : T_LD) << 22) | (NW'(store ? 2 + N : 2) << 30));
        exp_q.push_back(NW'(addr));
        exp_q.push_back('0);
        if (store)
            for (int k = 0; k < N; k++) begin
                for (int b = 0; b < NW / 8; b++)
                    f[b*8 +: 8] = s[k*(NW/8) + b] ? d[k*NW + b*8 +: 8] : 8'h00;
                exp_q.push_back(f);
            end
    endtask

    // Reference model: one packet in flight counted in flits, credits as plain integers.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            m_left = 0; m_rd = 0; m_wr = 0; m_last_wr = 1;
            exp_q.delete();
        end else begin
            idle_m = m_left == 0;
            rel = arvalid && m_rd < MAXO;
            wel = awvalid && wvalid && m_wr < MAXO;
`ifdef AXILITE_REQ_RD_PRIORITY_EN
            gw = idle_m && wel && !rel;
`else
            gw = idle_m && wel && (!rel || !m_last_wr);
`endif
            gr = idle_m && rel && !gw;
            check("arready", 64'(arready), 64'(gr));
            check("awready", 64'(awready), 64'(gw));
            check("wready", 64'(wready), 64'(gw));
            check("noc_valid", 64'(noc_valid), 64'(!idle_m));
            check("rd_outstanding", 64'(rd_out), 64'(m_rd));
            check("wr_outstanding", 64'(wr_out), 64'(m_wr));
            if (!idle_m && noc_ready) m_left--;
            if (ld_ack && m_rd > 0) m_rd--;
            if (st_ack && m_wr > 0) m_wr--;
            if (gr) begin
                push_pkt(0, araddr, wdata, wstrb);
                m_left = 3; m_rd++; m_last_wr = 0; rd_grants++;
            end
            if (gw) begin
                push_pkt(1, awaddr, wdata, wstrb);
                m_left = 3 + N; m_wr++; m_last_wr = 1; wr_grants++;
            end
        end
    end

    // Monitor: every presented flit must equal the head of the queue, stalled or not.
    always @(negedge clk) begin
        if (!rst && noc_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_flit: got %h expected none at %0t", noc_data, $time);
            end else begin
                check("flit", noc_data, exp_q[0]);
                if (noc_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic new_write();
        for (int i = 0; i < DW / 32; i++) wdata[i*32 +: 32] = $urandom;
        wstrb = $urandom_range(3) == 0 ? '1 : {$urandom, $urandom};
        awaddr = {$urandom, $urandom};
        awvalid = 1; wvalid = 1;
    endtask

    task automatic drive(input int cycles, input int p_req, input int p_rdy, input int p_ack);
        repeat (cycles) begin
            @(posedge clk); #1;
            if (rd_grants != rd_seen) begin rd_seen = rd_grants; arvalid = 0; end
            if (wr_grants != wr_seen) begin wr_seen = wr_grants; awvalid = 0; wvalid = 0; end
            if (!arvalid && int'($urandom_range(99)) < p_req) begin
                arvalid = 1; araddr = {$urandom, $urandom};
            end
            if (!awvalid && int'($urandom_range(99)) < p_req) new_write();
            noc_ready = int'($urandom_range(99)) < p_rdy;
            ld_ack = int'($urandom_range(99)) < p_ack;
            st_ack = int'($urandom_range(99)) < p_ack;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", 64'(arready), 64'(0));
        check("rst_awready", 64'(awready), 64'(0));
        check("rst_wready", 64'(wready), 64'(0));
        check("rst_valid", 64'(noc_valid), 64'(0));
        check("rst_data", noc_data, 64'(0));
        check("rst_rd", 64'(rd_out), 64'(0));
        check("rst_wr", 64'(wr_out), 64'(0));
        rst = 0;
        drive(40, 100, 100, 0);
        ld_ack = 1;
        drive(12, 100, 100, 0);
        drive(3000, 50, 50, 15);
        drive(150, 0, 100, 30);
        ld_ack = 0; st_ack = 0; arvalid = 0; awvalid = 0; wvalid = 0;
        @(posedge clk); #1;
        new_write();
        wstrb = '1;
        noc_ready = 1;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk); #1;
            if (wr_grants != wr_seen) begin wr_seen = wr_grants; awvalid = 0; wvalid = 0; end
            if (ld_ack || st_ack) begin ld_ack = 0; st_ack = 0; end
            if (!awvalid && wr_out == 0) st_ack = 0;
            if (awvalid && m_wr >= MAXO) st_ack = 1;
            done = !awvalid && m_left == N - 3;
        end
        check("reach_data3", 64'(done), 64'(1));
        st_ack = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("mid_rst_valid", 64'(noc_valid), 64'(0));
        check("mid_rst_data", noc_data, 64'(0));
        check("mid_rst_rd", 64'(rd_out), 64'(0));
        check("mid_rst_wr", 64'(wr_out), 64'(0));
        araddr = 64'h80; arvalid = 1;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            if (rd_grants != rd_seen) begin rd_seen = rd_grants; arvalid = 0; end
            done = !arvalid && m_left == 0 && exp_q.size() == 0;
        end
        check("load_after_rst", 64'(done), 64'(1));
        check("rd_after_load", 64'(rd_out), 64'(1));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/noc_request_axilite_arb.md
# noc_request_axilite_arb

Sequences AXI-lite master read (AR) and write (AW+W) requests onto the single outbound NoC request channel. It round-robins between reads and writes and serializes each winner into a Piton NoC packet: header0, header1, header2, then data flits for stores. It tracks outstanding loads and stores against a credit limit, so the response-side AXI-lite converter and its 16-entry read FIFO are never oversubscribed. It sits between the AXI-lite master and the NoC, and is the request-side companion of the response converter.

## Interface
- AXI_LITE_DATA_WIDTH, 512: AXI-lite data width. Must be an integer multiple of `NOC_DATA_WIDTH.
- AXI_LITE_ADDR_WIDTH, 64: AXI address width. Must be ≤ the `MSG_ADDR field width.
- MAX_OUTSTANDING, 8: per-type credit limit, range 1..15.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axi_araddr  in  AXI_LITE_ADDR_WIDTH  read address
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
- s_axi_awaddr  in  AXI_LITE_ADDR_WIDTH  write address
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
- s_axi_wdata  in  AXI_LITE_DATA_WIDTH  write data
- s_axi_wstrb  in  AXI_LITE_DATA_WIDTH/8  write strobes
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake
- noc_data_out  out  `NOC_DATA_WIDTH  packet flit
- noc_valid_out  out  1  flit valid
- noc_ready_in  in  1  NoC accepts the flit
- load_ack_done  in  1  one-cycle pulse from the response side when a load ACK has been fully delivered
- store_ack_done  in  1  one-cycle pulse from the response side when a store ACK has been fully delivered
- rd_outstanding, wr_outstanding  out  4  current credit counts

## Operation
- FSM states: IDLE, HDR0, HDR1, HDR2, DATA.
- Eligibility:
  - Read is eligible when arvalid is high and rd_outstanding < MAX_OUTSTANDING.
  - Write is eligible when awvalid and wvalid are both high and wr_outstanding < MAX_OUTSTANDING.
- Arbitration (IDLE only):
  - One-bit last_grant. If both are eligible, grant the type not granted last; otherwise grant the single eligible type.
  - arready is high only in IDLE with the read grant. awready and wready are high together only in IDLE with the write grant. AW and W are always accepted in the same cycle.
  - A handshake captures address, wdata and wstrb into registers, increments the matching outstanding counter, updates last_grant, and moves the FSM to HDR0.
- Packet contents:
  - HDR0: `MSG_TYPE = `MSG_TYPE_NC_LOAD_REQ or `MSG_TYPE_NC_STORE_REQ. `MSG_LENGTH = 2 for loads, 2 + N for stores, where N = AXI_LITE_DATA_WIDTH/`NOC_DATA_WIDTH. All other fields are 0.
  - HDR1: `MSG_ADDR = captured address, zero-extended.
  - HDR2: all zero.
  - DATA: N flits, lowest slice first, each slice masked bytewise by wstrb (a byte with strobe 0 is sent as 0).
- Transitions: HDR0→HDR1→HDR2 advance on noc_ready_in. From HDR2, a load returns to IDLE and a store enters DATA. DATA counts flits 0..N-1 and returns to IDLE after flit N-1 is accepted.
- Credits:
  - A counter increments on its handshake and decrements on its ack pulse.
  - Simultaneous handshake and ack for the same type leaves the counter unchanged.
  - An ack pulse while the counter is 0 is ignored and does not underflow.

## Timing
- Reset values: all ready outputs 0, noc_valid_out 0, noc_data_out 0, both counters 0, last_grant = write (so the first contention goes to the read), FSM IDLE.
- A handshake in cycle T puts HDR0 on the NoC with noc_valid_out high in cycle T+1.
- noc_valid_out and noc_data_out hold stable until noc_ready_in is seen.
- With noc_ready_in held high, a load occupies 3 cycles plus 1 return cycle in IDLE. A store occupies 3+N cycles plus 1 IDLE cycle.
- IDLE lasts at least one cycle between packets; there are no back-to-back grants without IDLE.
- Reset mid-packet abandons the packet and zeroes the credits. The response side is reset in the same cycle.

## Configuration
- AXILITE_REQ_RD_PRIORITY_EN:
  - Defined: an eligible read always wins over a write, and last_grant is unused.
  - Undefined: round-robin as described under Operation.

## Structure
- The shared package holds the FSM state encoding, the flit count N as a derived localparam, and the header field construction function.
- One sub-module, noc_req_credit_ctr, is instantiated twice (read and write). It holds the saturating up/down counter and the full flag.

## Test plan
- Single load to address 0x80 with noc_ready_in held high: 3 flits; HDR0 MSG_LENGTH = 2; HDR1 addr = 0x80; rd_outstanding goes to 1.
- Single store with 512-bit data 0x…0F0E…00 and wstrb = all ones, N = 8: 11 flits; data slice 0 first; MSG_LENGTH = 10.
- AR and AW/W held valid continuously after reset: grants alternate R, W, R, W; with AXILITE_REQ_RD_PRIORITY_EN defined, reads win until reads run out of credit.
- MAX_OUTSTANDING = 2 with no acks: the third arvalid gets no arready. One load_ack_done pulse lets the third read be accepted the next IDLE cycle.
- noc_ready_in toggled randomly at 50%: no flit is dropped or duplicated, and data is stable while stalled.
- rst asserted during DATA flit 3: the next cycle shows IDLE, noc_valid_out 0 and counters 0; a following load completes normally.
